quad_decoder: RTL

- Receive-side counterpart to the joystick-to-quadrature steering encoder.
- Samples a two-phase quadrature pair (A/B, as driven onto the steering inputs), synchronises and glitch-filters it, and decodes Gray-code transitions into a signed position count, per-step pulses and a direction flag.
- Used for real spinner/steering-wheel input and as the loopback checker for the encoder output.
- Sits in the CLK_VIDEO domain next to the input-mapping logic.

---
 rtl/quad_pkg.sv | 56 +++++
 rtl/quad_filter.sv | 79 +++++++
 rtl/quad_decoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared quadrature definitions: the 2-bit phase pair, the Gray sequence
// and the step classifier. The matching encoder walks the same table.
package quad_pkg;

    typedef logic [1:0] ab_t;

    // Gray sequence in forward order: 00 -> 01 -> 11 -> 10 -> 00
    localparam ab_t GRAY_00 = 2'b00;
    localparam ab_t GRAY_01 = 2'b01;
    localparam ab_t GRAY_11 = 2'b11;
    localparam ab_t GRAY_10 = 2'b10;

    // Decode state, one per Gray code; encoding equals the {A,B} pair
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } quad_state_t;

    typedef enum logic [1:0] {
        DELTA_NONE    = 2'd0,
        DELTA_FWD     = 2'd1,
        DELTA_REV     = 2'd2,
        DELTA_ILLEGAL = 2'd3
    } delta_t;

    // Successor of a code in the forward direction
    function automatic ab_t gray_next(input ab_t cur);
        ab_t nxt;
        case (cur)
            GRAY_00: nxt = GRAY_01;
            GRAY_01: nxt = GRAY_11;
            GRAY_11: nxt = GRAY_10;
            GRAY_10: nxt = GRAY_00;
            default: nxt = GRAY_00;
        endcase
        return nxt;
    endfunction

    // Classify a transition: forward, reverse, none, or a two-bit jump
    function automatic delta_t quad_delta(input ab_t prev, input ab_t cur);
        delta_t d;
        if (cur == prev) begin
            d = DELTA_NONE;
        end else if (cur == gray_next(prev)) begin
            d = DELTA_FWD;
        end else if (prev == gray_next(cur)) begin
            d = DELTA_REV;
        end else begin
            d = DELTA_ILLEGAL;
        end
        return d;
    endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchroniser plus stability filter for the quadrature pair.
// Both phases are filtered as one 2-bit value so a change is accepted as a
// unit; the filtered pair only moves after filt_len consecutive equal samples.
module quad_filter
    import quad_pkg::*;
#(
    parameter int FILT_W = 4
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              a_in,
    input  logic              b_in,
    input  logic [FILT_W-1:0] filt_len,
    output ab_t               ab_state
);

    localparam logic [FILT_W-1:0] CNT_ZERO = {FILT_W{1'b0}};
    localparam logic [FILT_W-1:0] CNT_ONE  = {{(FILT_W-1){1'b0}}, 1'b1};
    localparam logic [FILT_W-1:0] CNT_MAX  = {FILT_W{1'b1}};

    ab_t               sync1_r;
    ab_t               sync2_r;
    ab_t               cand_r;
    ab_t               filt_r;
    logic [FILT_W-1:0] cnt_r;

    logic [FILT_W-1:0] cnt_next_s;
    logic [FILT_W-1:0] thresh_s;
    logic              accept_s;

    // Two-stage synchroniser for the asynchronous phase inputs
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_r <= GRAY_00;
            sync2_r <= GRAY_00;
        end else begin
            sync1_r <= {a_in, b_in};
            sync2_r <= sync1_r;
        end
    end

    // Stability count including the current sample; accept once it reaches the threshold
    always_comb begin
        cnt_next_s = cnt_r;
        thresh_s   = CNT_ONE;
        accept_s   = 1'b0;
        if (filt_len == CNT_ZERO) begin
            thresh_s = CNT_ONE;
        end else begin
            thresh_s = filt_len;
        end
        if (sync2_r != cand_r) begin
            cnt_next_s = CNT_ONE;
        end else if ((cnt_r < filt_len) && (cnt_r != CNT_MAX)) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
        accept_s = (cnt_next_s >= thresh_s);
    end

    // Candidate, counter and filtered-state registers
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            cand_r <= GRAY_00;
            cnt_r  <= CNT_ZERO;
            filt_r <= GRAY_00;
        end else begin
            cand_r <= sync2_r;
            cnt_r  <= cnt_next_s;
            if (accept_s) begin
                filt_r <= sync2_r;
            end
        end
    end

    assign ab_state = filt_r;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filters the A/B pair and turns Gray-code transitions
// into a signed position, a one-cycle step pulse, a direction flag and a
// sticky error for two-bit jumps. All outputs are registered.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int POS_W    = 8,
    parameter int FILT_W   = 4,
    parameter int SATURATE = 0,
    parameter int X4       = 1
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              SteerA_I,
    input  logic              SteerB_I,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              clear,
    output logic [POS_W-1:0]  position,
    output logic              step,
    output logic              dir,
    output logic              err,
    output logic [1:0]        ab_state
);

    localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};
    localparam logic [POS_W-1:0] POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0] POS_MAX  = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] POS_MIN  = {1'b1, {(POS_W-1){1'b0}}};

    ab_t              ab_s;
    quad_state_t      prev_r;
    quad_state_t      prev_next_s;
    delta_t           delta_s;

    logic [POS_W-1:0] position_r;
    logic             step_r;
    logic             dir_r;
    logic             err_r;

    logic             count_up_s;
    logic             count_dn_s;
    logic             illegal_s;
    logic [POS_W-1:0] pos_next_s;
    logic             step_next_s;
    logic             dir_next_s;
    logic             err_next_s;

    quad_filter #(
        .FILT_W (FILT_W)
    ) u_filter (
        .CLK      (CLK),
        .Reset_n  (Reset_n),
        .a_in     (SteerA_I),
        .b_in     (SteerB_I),
        .filt_len (filt_len),
        .ab_state (ab_s)
    );

    // Decode state register: tracks the previously seen filtered code
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            prev_r <= S00;
        end else begin
            prev_r <= prev_next_s;
        end
    end

    // Next-state, count decision and next output values
    always_comb begin
        prev_next_s = quad_state_t'(ab_s);
        delta_s     = quad_delta(ab_t'(prev_r), ab_s);
        count_up_s  = 1'b0;
        count_dn_s  = 1'b0;
        illegal_s   = 1'b0;
        pos_next_s  = position_r;
        err_next_s  = err_r;
        dir_next_s  = dir_r;

        // In x1 mode only the arrival at 00 counts (10->00 up, 01->00 down)
        case (delta_s)
            DELTA_FWD: begin
                if ((X4 != 0) || (ab_s == GRAY_00)) begin
                    count_up_s = 1'b1;
                end else begin
                    count_up_s = 1'b0;
                end
            end
            DELTA_REV: begin
                if ((X4 != 0) || (ab_s == GRAY_00)) begin
                    count_dn_s = 1'b1;
                end else begin
                    count_dn_s = 1'b0;
                end
            end
            DELTA_ILLEGAL: illegal_s = 1'b1;
            default:       illegal_s = 1'b0;
        endcase

        // Clear overrides a coinciding count on position and err only
        if (clear) begin
            pos_next_s = POS_ZERO;
        end else if (count_up_s) begin
            if ((SATURATE != 0) && (position_r == POS_MAX)) begin
                pos_next_s = position_r;
            end else begin
                pos_next_s = position_r + POS_ONE;
            end
        end else if (count_dn_s) begin
            if ((SATURATE != 0) && (position_r == POS_MIN)) begin
                pos_next_s = position_r;
            end else begin
                pos_next_s = position_r - POS_ONE;
            end
        end else begin
            pos_next_s = position_r;
        end

        if (clear) begin
            err_next_s = 1'b0;
        end else if (illegal_s) begin
            err_next_s = 1'b1;
        end else begin
            err_next_s = err_r;
        end

        if (count_up_s) begin
            dir_next_s = 1'b1;
        end else if (count_dn_s) begin
            dir_next_s = 1'b0;
        end else begin
            dir_next_s = dir_r;
        end

        step_next_s = count_up_s | count_dn_s;
    end

    // Registered outputs: position, step pulse, direction and sticky error
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            position_r <= POS_ZERO;
            step_r     <= 1'b0;
            dir_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            position_r <= pos_next_s;
            step_r     <= step_next_s;
            dir_r      <= dir_next_s;
            err_r      <= err_next_s;
        end
    end

    assign position = position_r;
    assign step     = step_r;
    assign dir      = dir_r;
    assign err      = err_r;
    assign ab_state = ab_s;

endmodule
